// File: rtl/peak_result_streamer_pkg.sv
// peak_result_streamer_pkg: shared widths and FSM encoding for the peak result streamer.
package peak_result_streamer_pkg;
  localparam int NP_DEF = 16;
  localparam int PIX_DEF = 4;
  typedef enum logic {IDLE, STREAM} state_t;
endpackage

// File: rtl/peak_result_streamer.sv
// peak_result_streamer: double-buffers per-pixel peak results and streams them one pixel per beat.
module peak_result_streamer
  import peak_result_streamer_pkg::*;
#(
  parameter int NP = NP_DEF,
  parameter int PIX = PIX_DEF,
  parameter int IDXW = 8
) (
  input  logic              clk,
  input  logic              res,
  input  logic              frame_done,
  input  logic [NP*PIX-1:0] result,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [IDXW-1:0]   out_pixel,
  output logic [NP-1:0]     out_peak,
  output logic              out_last,
  output logic [7:0]        out_frame,
  output logic              busy,
  output logic [7:0]        drop_cnt
);
  localparam logic [IDXW-1:0] LAST = IDXW'(PIX - 1);
  localparam int SW = $clog2(NP * PIX);
  state_t state, state_n;
  logic [NP*PIX-1:0] pend, active;
  logic pend_full;
  logic [IDXW-1:0] idx;
  logic [SW-1:0] base;
  logic fire, at_last, xfer, take;
  always_comb begin
    fire = (state == STREAM) && out_ready;
    at_last = idx == LAST;
    // a finishing frame hands off straight to the pending one, avoiding a bubble
    xfer = pend_full && ((state == IDLE) || (fire && at_last));
    take = frame_done && (!pend_full || xfer);
    state_n = xfer ? STREAM : (fire && at_last) ? IDLE : state;
    base = SW'(idx) * SW'(NP);
    out_valid = state == STREAM;
    out_pixel = out_valid ? idx : '0;
    out_peak = out_valid ? active[base +: NP] : '0;
    out_last = out_valid && at_last;
    busy = out_valid || pend_full;
  end
  always_ff @(posedge clk)
    if (res) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (!res && take) pend <= result;
    if (!res && xfer) active <= pend;
  end
  always_ff @(posedge clk) begin
    if (res) begin
      pend_full <= 1'b0;
      idx <= '0;
      out_frame <= '0;
      drop_cnt <= '0;
    end else begin
      if (xfer) idx <= '0;
      else if (fire && !at_last) idx <= idx + 1'b1;
      if (fire && at_last) out_frame <= out_frame + 8'd1;
      if (take) pend_full <= 1'b1;
      else if (xfer) pend_full <= 1'b0;
      if (frame_done && pend_full && !xfer && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule
